// File: rtl/crc_seq_pkg.sv
// Shared types, sizes and the CRC-32 table helper for the CRC sequencer.
package crc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int CRC_W     = 32;
  localparam int MAX_BYTES = 4;
  localparam int CNT_W     = 3;

  localparam logic [CRC_W-1:0] CRC_POLY = 32'hEDB8_8320;

  // One entry of the reflected CRC-32 table; elaborates to a 256-entry ROM.
  function automatic logic [CRC_W-1:0] crc_table_entry(input logic [7:0] idx);
    logic [CRC_W-1:0] c;
    c = {24'd0, idx};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Byte counts above MAX_BYTES saturate rather than wrap.
  function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] n);
    return (n > 3'd4) ? 3'd4 : n;
  endfunction

endpackage

// File: rtl/crc.sv
// Single-byte table-driven CRC-32 step: purely combinational ROM lookup.
module crc
  import crc_seq_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [CRC_W-1:0] req_data0,
  input  logic [CRC_W-1:0] req_data1,
  output logic [CRC_W-1:0] crc_out
);

  logic [7:0] idx_s;
  logic       unused_s;

  // Clock/reset kept on the port list for a uniform interface; the step has no state.
  assign unused_s = ^{i_clk, i_rst, req_data0[31:8]};

  // Table lookup on the low byte, then fold in the shifted running CRC.
  always_comb begin
    idx_s   = req_data0[7:0] ^ req_data1[7:0];
    crc_out = crc_table_entry(idx_s) ^ {8'd0, req_data1[31:8]};
  end

endmodule

// File: rtl/crc_seq.sv
// CX request sequencer: feeds up to four bytes, LSB first, through one crc step unit.
module crc_seq
  import crc_seq_pkg::*;
#(
  parameter int               ID_W    = 4,
  parameter logic [CRC_W-1:0] XOR_OUT = 32'hFFFF_FFFF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ID_W-1:0]  req_id,
  input  logic [CRC_W-1:0] req_crc,
  input  logic [CRC_W-1:0] req_data,
  input  logic [CNT_W-1:0] req_nbytes,
  input  logic             req_final,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [ID_W-1:0]  resp_id,
  output logic [CRC_W-1:0] resp_crc,
  output logic             busy
);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CRC_W-1:0] crc_r;
  logic [CRC_W-1:0] data_r;
  logic             final_r;
  logic [CRC_W-1:0] step_out_s;
  logic [CNT_W-1:0] nbytes_s;

  assign req_ready = (state_r == IDLE);
  assign nbytes_s  = clamp_count(req_nbytes);

  crc u_crc (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .req_data0 ({24'd0, data_r[7:0]}),
    .req_data1 (crc_r),
    .crc_out   (step_out_s)
  );

  // Sequencer FSM with byte counter, shift register and registered response.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r    <= IDLE;
      cnt_r      <= 3'd0;
      crc_r      <= 32'd0;
      data_r     <= 32'd0;
      final_r    <= 1'b0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_crc   <= 32'd0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            resp_id <= req_id;
            crc_r   <= req_crc;
            data_r  <= req_data;
            final_r <= req_final;
            cnt_r   <= nbytes_s;
            busy    <= 1'b1;
            if (nbytes_s == 3'd0) begin
              // Zero-byte request: pass the CRC through, still honouring final.
              resp_crc   <= req_final ? (req_crc ^ XOR_OUT) : req_crc;
              resp_valid <= 1'b1;
              state_r    <= RESP;
            end else begin
              state_r <= RUN;
            end
          end
        end
        RUN: begin
          crc_r  <= step_out_s;
          data_r <= data_r >> 8;
          cnt_r  <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            resp_crc   <= final_r ? (step_out_s ^ XOR_OUT) : step_out_s;
            resp_valid <= 1'b1;
            state_r    <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r    <= IDLE;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc_seq.sv
// Directed self-checking bench for crc_seq using known CRC-32 vectors.
module tb_crc_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_id = 4'd0;
  logic [31:0] req_crc = 32'd0;
  logic [31:0] req_data = 32'd0;
  logic [2:0]  req_nbytes = 3'd0;
  logic        req_final = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [3:0]  resp_id;
  logic [31:0] resp_crc;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  crc_seq dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_id     (req_id),
    .req_crc    (req_crc),
    .req_data   (req_data),
    .req_nbytes (req_nbytes),
    .req_final  (req_final),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_crc   (resp_crc),
    .busy       (busy)
  );

  always #5 i_clk = ~i_clk;

  // Drive one request at a negedge, accept on the next edge (c0), then count
  // cycles until resp_valid is seen; returns the c0-relative cycle number.
  task automatic send_req(input logic [3:0] id, input logic [31:0] c, input logic [31:0] d,
                          input logic [2:0] nb, input logic fin, output int lat);
    @(negedge i_clk);
    req_valid  = 1'b1;
    req_id     = id;
    req_crc    = c;
    req_data   = d;
    req_nbytes = nb;
    req_final  = fin;
    @(posedge i_clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge i_clk);
      if (resp_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  // Handshake the current response (called at a negedge).
  task automatic consume;
    resp_ready = 1'b1;
    @(posedge i_clk);
    #1 resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL reset_flags: got rdy/vld/busy=%b required 100", {req_ready, resp_valid, busy});
    end
    n_cmp++;
    if (resp_crc !== 32'd0 || resp_id !== 4'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got crc=%h id=%0d required 0/0", resp_crc, resp_id);
    end
  endtask

  task automatic test_single_byte;
    int lat;
    send_req(4'd3, 32'hFFFF_FFFF, 32'h0000_0061, 3'd1, 1'b1, lat);
    n_cmp++;
    if (lat !== 2) begin
      n_bad++;
      $display("FAIL a_latency: got %0d required 2", lat);
    end
    n_cmp++;
    if (resp_crc !== 32'hE8B7_BE43 || resp_id !== 4'd3 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL a_result: got crc=%h id=%0d busy=%b required E8B7BE43/3/1", resp_crc, resp_id, busy);
    end
    consume();
    @(negedge i_clk);
    n_cmp++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL a_release: got rdy/vld/busy=%b required 100", {req_ready, resp_valid, busy});
    end
  endtask

  task automatic test_four_bytes;
    int lat;
    send_req(4'd9, 32'hFFFF_FFFF, 32'h3433_3231, 3'd4, 1'b1, lat);
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL s1234_latency: got %0d required 5", lat);
    end
    n_cmp++;
    if (resp_crc !== 32'h9BE3_E0A3 || resp_id !== 4'd9) begin
      n_bad++;
      $display("FAIL s1234_result: got crc=%h id=%0d required 9BE3E0A3/9", resp_crc, resp_id);
    end
    consume();
  endtask

  task automatic test_count_edges;
    int lat;
    send_req(4'd5, 32'h1234_5678, 32'hDEAD_BEEF, 3'd0, 1'b0, lat);
    n_cmp++;
    if (lat !== 1 || resp_crc !== 32'h1234_5678) begin
      n_bad++;
      $display("FAIL zero_bytes: got lat=%0d crc=%h required 1/12345678", lat, resp_crc);
    end
    consume();
    send_req(4'd6, 32'h1234_5678, 32'hDEAD_BEEF, 3'd0, 1'b1, lat);
    n_cmp++;
    if (lat !== 1 || resp_crc !== 32'hEDCB_A987) begin
      n_bad++;
      $display("FAIL zero_bytes_final: got lat=%0d crc=%h required 1/EDCBA987", lat, resp_crc);
    end
    consume();
    send_req(4'd7, 32'hFFFF_FFFF, 32'h3433_3231, 3'd7, 1'b1, lat);
    n_cmp++;
    if (lat !== 5 || resp_crc !== 32'h9BE3_E0A3) begin
      n_bad++;
      $display("FAIL nbytes7_clamp: got lat=%0d crc=%h required 5/9BE3E0A3", lat, resp_crc);
    end
    consume();
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [31:0] mid;
    int unstable;
    send_req(4'd1, 32'hFFFF_FFFF, 32'h0000_3231, 3'd2, 1'b0, lat);
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL chain1_latency: got %0d required 3", lat);
    end
    mid = resp_crc;
    // Hold off the response while offering a competing request.
    req_valid = 1'b1;
    req_id    = 4'd15;
    req_crc   = 32'h0;
    req_nbytes = 3'd1;
    unstable  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      if (resp_valid !== 1'b1 || resp_crc !== mid || resp_id !== 4'd1 || req_ready !== 1'b0)
        unstable++;
    end
    req_valid = 1'b0;
    n_cmp++;
    if (unstable !== 0) begin
      n_bad++;
      $display("FAIL backpressure_hold: got %0d unstable cycles required 0", unstable);
    end
    consume();
    @(negedge i_clk);
    n_cmp++;
    if ({req_ready, resp_valid, busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL backpressure_release: got rdy/vld/busy=%b required 100", {req_ready, resp_valid, busy});
    end
    send_req(4'd2, mid, 32'h0000_3433, 3'd2, 1'b1, lat);
    n_cmp++;
    if (lat !== 3 || resp_crc !== 32'h9BE3_E0A3 || resp_id !== 4'd2) begin
      n_bad++;
      $display("FAIL chain2_result: got lat=%0d crc=%h id=%0d required 3/9BE3E0A3/2", lat, resp_crc, resp_id);
    end
    consume();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int spurious;
    @(negedge i_clk);
    req_valid  = 1'b1;
    req_id     = 4'd4;
    req_crc    = 32'hFFFF_FFFF;
    req_data   = 32'h3433_3231;
    req_nbytes = 3'd4;
    req_final  = 1'b1;
    @(posedge i_clk);
    #1 req_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b1;
    @(posedge i_clk);
    #1 i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({req_ready, resp_valid, busy} !== 3'b100 || resp_crc !== 32'd0) begin
      n_bad++;
      $display("FAIL rst_run_idle: got rdy/vld/busy=%b crc=%h required 100/0", {req_ready, resp_valid, busy}, resp_crc);
    end
    spurious = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (resp_valid !== 1'b0) spurious++;
    end
    n_cmp++;
    if (spurious !== 0) begin
      n_bad++;
      $display("FAIL rst_run_noresp: got %0d valid cycles required 0", spurious);
    end
    send_req(4'd3, 32'hFFFF_FFFF, 32'h0000_0061, 3'd1, 1'b1, lat);
    n_cmp++;
    if (lat !== 2 || resp_crc !== 32'hE8B7_BE43 || resp_id !== 4'd3) begin
      n_bad++;
      $display("FAIL rst_run_next: got lat=%0d crc=%h id=%0d required 2/E8B7BE43/3", lat, resp_crc, resp_id);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_four_bytes();
    test_count_edges();
    test_back_to_back();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
